// File: rtl/race_pkg.sv
`default_nettype none
// ============================================================================
// race_pkg: shared states, default constants and result record for the
// race scheduler and its downstream results logger.            Rev 1.0
// ============================================================================
package race_pkg;

  localparam int DEF_N_LANES = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 1000;

  function automatic int lane_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_LANE_W = lane_width(DEF_N_LANES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_LANE_W-1:0] lane;
    logic [DEF_CNT_W-1:0]  cycles;
    logic                  timeout;
  } result_t;

endpackage
`default_nettype wire

// File: rtl/race_scheduler_if.sv
`default_nettype none
// ============================================================================
// race_scheduler_if: lane handshake and result bus of the race scheduler.
//                                                                Rev 1.0
// ============================================================================
interface race_scheduler_if
  import race_pkg::*;
#(
  parameter int N_LANES = DEF_N_LANES,
  parameter int CNT_W   = DEF_CNT_W
) ();

  localparam int LANE_W = lane_width(N_LANES);

  logic [N_LANES-1:0] ready;
  logic [N_LANES-1:0] done;
  logic [N_LANES-1:0] start;
  logic               busy;
  logic [LANE_W-1:0]  grant_lane;
  logic               result_valid;
  logic [LANE_W-1:0]  result_lane;
  logic [CNT_W-1:0]   result_cycles;
  logic               result_timeout;

  modport master (
    input  ready, done,
    output start, busy, grant_lane,
    output result_valid, result_lane, result_cycles, result_timeout
  );

  modport slave (
    output ready, done,
    input  start, busy, grant_lane,
    input  result_valid, result_lane, result_cycles, result_timeout
  );

endinterface
`default_nettype wire

// File: rtl/race_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter: combinational round-robin pick of the first requesting lane at
// or above the pointer, wrapping to the lowest lane.            Rev 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N_LANES = 4,
  parameter int LANE_W  = 2
) (
  input  logic [N_LANES-1:0] req,
  input  logic [LANE_W-1:0]  ptr,
  output logic [N_LANES-1:0] gnt,
  output logic [LANE_W-1:0]  idx
);

  logic hit;

  // First pass covers lanes ptr..N-1; the second only matters when that
  // range is empty, so its lowest hit is the wrapped choice.
  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      if (!hit && req[i] && (i >= int'(ptr))) begin
        hit    = 1'b1;
        gnt[i] = 1'b1;
        idx    = LANE_W'(i);
      end
    end
    for (int i = 0; i < N_LANES; i++) begin
      if (!hit && req[i]) begin
        hit    = 1'b1;
        gnt[i] = 1'b1;
        idx    = LANE_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/race_scheduler.sv
`default_nettype none
// ============================================================================
// race_scheduler: round-robin owner of the single race slot; times each run
// and reports one result per completed or aborted run.
// Optional run abort on timeout: define RACE_SCHED_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module race_scheduler
  import race_pkg::*;
#(
  parameter int N_LANES = DEF_N_LANES,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  race_scheduler_if.master bus
);

  localparam int               LANE_W       = lane_width(N_LANES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
`ifdef RACE_SCHED_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [LANE_W-1:0]  ptr;
  logic [CNT_W-1:0]   counter;
  logic [N_LANES-1:0] start;
  logic               busy;
  logic [LANE_W-1:0]  grant_lane;
  logic               result_valid;
  logic [LANE_W-1:0]  result_lane;
  logic [CNT_W-1:0]   result_cycles;

  logic [N_LANES-1:0] arb_gnt;
  logic [LANE_W-1:0]  arb_idx;
  logic               done_g;
  logic               ready_g;
  logic               timeout_hit;
  logic [LANE_W-1:0]  ptr_next;
  logic               do_grant;
  logic               do_count;
  logic               do_finish;
  logic               do_abort;
  logic               bad_state;

  rr_arbiter #(
    .N_LANES (N_LANES),
    .LANE_W  (LANE_W)
  ) u_arb (
    .req (bus.ready),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign done_g      = bus.done[grant_lane];
  assign ready_g     = bus.ready[grant_lane];
  assign timeout_hit = TIMEOUT_EN && (counter == TIMEOUT_LAST);
  assign ptr_next    = (grant_lane == LANE_W'(N_LANES - 1)) ? '0 : grant_lane + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_count  = 1'b0;
    do_finish = 1'b0;
    do_abort  = 1'b0;
    bad_state = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.ready) begin
          do_grant  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // done beats a coincident timeout
        if (done_g) begin
          do_finish = 1'b1;
          state_nxt = RELEASE;
        end else if (timeout_hit) begin
          do_abort  = 1'b1;
          state_nxt = RELEASE;
        end else begin
          do_count = 1'b1;
        end
      end
      RELEASE: begin
        if (!done_g && !ready_g) state_nxt = IDLE;
      end
      default: begin
        bad_state = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= '0;
      counter       <= '0;
      start         <= '0;
      busy          <= 1'b0;
      grant_lane    <= '0;
      result_valid  <= 1'b0;
      result_lane   <= '0;
      result_cycles <= '0;
    end else begin
      result_valid <= 1'b0;
      busy         <= (state_nxt == RUN) || (state_nxt == RELEASE);
      if (do_grant) begin
        start      <= arb_gnt;
        grant_lane <= arb_idx;
        counter    <= '0;
      end
      if (do_count && (counter != CNT_MAX)) counter <= counter + 1'b1;
      if (do_finish || do_abort) begin
        start         <= '0;
        result_valid  <= 1'b1;
        result_lane   <= grant_lane;
        result_cycles <= do_abort ? TIMEOUT_VAL : counter;
        ptr           <= ptr_next;
      end
      if (bad_state) start <= '0;
    end
  end

`ifdef RACE_SCHED_TIMEOUT_EN
  logic result_timeout;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        result_timeout <= 1'b0;
    else if (do_finish || do_abort) result_timeout <= do_abort;
  end
  assign bus.result_timeout = result_timeout;
`else
  assign bus.result_timeout = 1'b0;
`endif

  assign bus.start         = start;
  assign bus.busy          = busy;
  assign bus.grant_lane    = grant_lane;
  assign bus.result_valid  = result_valid;
  assign bus.result_lane   = result_lane;
  assign bus.result_cycles = result_cycles;

endmodule
`default_nettype wire

// File: tb/tb_race_scheduler.sv
`default_nettype none
// ============================================================================
// tb_race_scheduler: directed scenarios plus randomized racer lanes, checked
// every cycle against a timestamp-based model of the scheduler.  Rev 1.0
// ============================================================================
module tb_race_scheduler;
  import race_pkg::*;

  localparam int N   = 4;
  localparam int CW  = 16;
  localparam int TMO = 20;
  localparam int LW  = lane_width(N);
`ifdef RACE_SCHED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] rdy = '0;
  logic [N-1:0] dn  = '0;

  race_scheduler_if #(.N_LANES(N), .CNT_W(CW)) bus ();
  assign bus.ready = rdy;
  assign bus.done  = dn;

  race_scheduler #(.N_LANES(N), .CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  bit auto_mode = 1'b0;

  // model: phase 0 idle, 1 racing, 2 waiting for lane to let go
  int           m_phase, m_lane, m_ptr;
  longint       m_cyc, m_t0;
  logic [N-1:0] e_start;
  logic         e_busy, e_rv;
  logic [LW-1:0] e_gl;
  result_t      e_res;

  int ag_ph  [N];
  int ag_cnt [N];

  function automatic logic bit_at(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [N-1:0] set_bit(input logic [N-1:0] v, input int i, input logic b);
    logic [N-1:0] m;
    m = N'(1) << i;
    return b ? (v | m) : (v & ~m);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_lane  = 0;
    m_ptr   = 0;
    e_start = '0;
    e_busy  = 1'b0;
    e_rv    = 1'b0;
    e_gl    = '0;
    e_res   = '0;
  endtask

  task automatic model_finish(input longint cycles, input logic tmo);
    e_rv          = 1'b1;
    e_res.lane    = LW'(m_lane);
    e_res.cycles  = CW'(cycles);
    e_res.timeout = tmo;
    e_start       = '0;
    m_ptr         = (m_lane + 1) % N;
    m_phase       = 2;
  endtask

  task automatic model_edge();
    longint k;
    bit     found;
    m_cyc++;
    e_rv = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!found && bit_at(rdy, (m_ptr + i) % N)) begin
            found  = 1'b1;
            m_lane = (m_ptr + i) % N;
          end
        end
        if (found) begin
          m_phase = 1;
          m_t0    = m_cyc;
          e_start = N'(1) << m_lane;
          e_gl    = LW'(m_lane);
        end
      end
      1: begin
        // k = edges since start rose; run length is k-1
        k = m_cyc - m_t0;
        if (bit_at(dn, m_lane))
          model_finish((k - 1 > 65535) ? 65535 : k - 1, 1'b0);
        else if (TMO_EN && k == TMO)
          model_finish(TMO, 1'b1);
      end
      default: begin
        if (!bit_at(dn, m_lane) && !bit_at(rdy, m_lane)) m_phase = 0;
      end
    endcase
    e_busy = (m_phase != 0);
  endtask

  task automatic compare();
    chk("start", bus.start, e_start);
    chk("start_onehot0", $onehot0(bus.start), 1'b1);
    chk("busy", bus.busy, e_busy);
    chk("grant_lane", bus.grant_lane, e_gl);
    chk("result_valid", bus.result_valid, e_rv);
    chk("result_lane", bus.result_lane, e_res.lane);
    chk("result_cycles", bus.result_cycles, e_res.cycles);
    chk("result_timeout", bus.result_timeout, e_res.timeout);
  endtask

  task automatic drive_agents();
    int len;
    for (int i = 0; i < N; i++) begin
      case (ag_ph[i])
        0: begin
          dn = set_bit(dn, i, $urandom_range(0, 7) == 0);
          if (ag_cnt[i] == 0) begin
            rdy = set_bit(rdy, i, 1'b1);
            ag_ph[i] = 1;
          end else ag_cnt[i]--;
        end
        1: begin
          if (bit_at(bus.start, i)) begin
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 25) : $urandom_range(0, 9);
            if (len == 0) begin
              dn = set_bit(dn, i, 1'b1);
              ag_ph[i] = 3;
            end else begin
              dn = set_bit(dn, i, 1'b0);
              ag_cnt[i] = len;
              ag_ph[i] = 2;
            end
          end else dn = set_bit(dn, i, $urandom_range(0, 3) == 0);
        end
        2: begin
          if (!bit_at(bus.start, i)) begin
            ag_ph[i] = 4;
            ag_cnt[i] = $urandom_range(0, 3);
          end else if (ag_cnt[i] == 1) begin
            dn = set_bit(dn, i, 1'b1);
            ag_ph[i] = 3;
          end else ag_cnt[i]--;
        end
        3: begin
          if (!bit_at(bus.start, i)) begin
            ag_ph[i] = 4;
            ag_cnt[i] = $urandom_range(0, 3);
          end
        end
        default: begin
          dn = set_bit(dn, i, 1'b0);
          if (ag_cnt[i] == 0) begin
            rdy = set_bit(rdy, i, 1'b0);
            ag_ph[i] = 0;
            ag_cnt[i] = $urandom_range(0, 4);
          end else ag_cnt[i]--;
        end
      endcase
    end
  endtask

  task automatic step();
    if (auto_mode) begin
      @(negedge clk);
      drive_agents();
    end
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic run_one(input int exp, input int len, input logic [N-1:0] mask_after);
    int n;
    n = 0;
    while (bus.start == '0 && n < 20) begin
      step();
      n++;
    end
    if (bus.start == '0) begin
      nchk++;
      nerr++;
      $display("FAIL grant_wait: got no start expected lane %0d", exp);
      return;
    end
    chk("run_grant_lane", bus.grant_lane, exp);
    chk("run_start", bus.start, N'(1) << exp);
    repeat (len) step();
    dn = set_bit(dn, exp, 1'b1);
    step();
    chk("run_res_valid", bus.result_valid, 1'b1);
    chk("run_res_lane", bus.result_lane, exp);
    chk("run_res_cycles", bus.result_cycles, len);
    chk("run_res_timeout", bus.result_timeout, 1'b0);
    chk("run_start_drop", bus.start, 0);
    dn  = set_bit(dn, exp, 1'b0);
    rdy = set_bit(rdy, exp, 1'b0);
    step();
    chk("run_back_idle", bus.busy, 1'b0);
    rdy = mask_after;
  endtask

  initial begin
    model_reset();
    m_cyc = 0;
    m_t0  = 0;

    repeat (3) step();
    chk("rst_start", bus.start, 0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_grant", bus.grant_lane, 0);
    chk("rst_cycles", bus.result_cycles, 0);
    chk("rst_valid", bus.result_valid, 1'b0);
    rst = 1'b0;

    // round robin 0,1,2,3,0,1,2,3 then fairness after wrap with 1001
    rdy = 4'b1111;
    for (int i = 0; i < 8; i++) run_one(i % 4, 1 + i, (i == 7) ? 4'b1001 : 4'b1111);
    run_one(0, 2, 4'b1001);
    run_one(3, 0, 4'b0001);

    // single lane, done on the 6th edge after start
    run_one(0, 5, 4'b1110);

    // release hold: lane 1 keeps ready high after its result
    step();
    chk("hold_grant", bus.start, 4'b0010);
    repeat (3) step();
    dn = 4'b0010;
    step();
    chk("hold_res_cycles", bus.result_cycles, 3);
    dn = 4'b0000;
    repeat (10) begin
      step();
      chk("hold_no_start", bus.start, 0);
      chk("hold_busy", bus.busy, 1'b1);
    end
    rdy = 4'b1100;
    step();
    chk("hold_idle", bus.busy, 1'b0);
    step();
    chk("hold_next_grant", bus.start, 4'b0100);

    // lane 2 never finishes
`ifdef RACE_SCHED_TIMEOUT_EN
    repeat (TMO - 1) begin
      step();
      chk("tmo_still_running", bus.start, 4'b0100);
    end
    step();
    chk("tmo_valid", bus.result_valid, 1'b1);
    chk("tmo_cycles", bus.result_cycles, TMO);
    chk("tmo_flag", bus.result_timeout, 1'b1);
    chk("tmo_lane", bus.result_lane, 2);
    chk("tmo_start_drop", bus.start, 0);
`else
    repeat (40) begin
      step();
      chk("stuck_start", bus.start, 4'b0100);
      chk("stuck_no_result", bus.result_valid, 1'b0);
    end
    dn = 4'b0100;
    step();
    chk("stuck_cycles", bus.result_cycles, 40);
    chk("stuck_flag", bus.result_timeout, 1'b0);
    dn = 4'b0000;
`endif
    rdy = 4'b1000;
    step();
    chk("tmo_idle", bus.busy, 1'b0);
    step();
    chk("tmo_next_grant", bus.start, 4'b1000);
    chk("tmo_next_lane", bus.grant_lane, 3);
    repeat (2) step();
    dn = 4'b1000;
    step();
    chk("lane3_cycles", bus.result_cycles, 2);
    dn  = 4'b0000;
    rdy = 4'b0000;
    step();

    // async reset in the middle of a run with the pointer at 1
    rdy = 4'b0001;
    run_one(0, 1, 4'b0100);
    step();
    chk("pre_rst_grant", bus.start, 4'b0100);
    repeat (3) step();
    #2;
    rst = 1'b1;
    rdy = 4'b0101;
    #1;
    chk("async_rst_start", bus.start, 0);
    chk("async_rst_valid", bus.result_valid, 1'b0);
    chk("async_rst_busy", bus.busy, 1'b0);
    model_reset();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_grant", bus.start, 4'b0001);
    dn = 4'b0001;
    step();
    dn  = 4'b0000;
    rdy = 4'b0000;
    step();

    // randomized racers
    for (int i = 0; i < N; i++) begin
      ag_ph[i]  = 0;
      ag_cnt[i] = $urandom_range(0, 4);
    end
    auto_mode = 1'b1;
    repeat (3000) step();
    auto_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
